// File: rtl/filter_seq_ctrl_if.sv
// Handshake/control bundle between the tap-serial FIR sequencer and its datapath.
// The master side drives sample ticks and the overrun clear; the slave side is the sequencer.
interface filter_seq_ctrl_if #(
  parameter int IDX_W = 3
);
  logic             rx_done_tick;
  logic             clr_ovr;
  logic             en_shift;
  logic             acc_clr;
  logic             acc_en;
  logic [IDX_W-1:0] sel_tap;
  logic             en_out;
  logic             listo;
  logic             busy;
  logic             overrun;

  modport master (
    output rx_done_tick, clr_ovr,
    input  en_shift, acc_clr, acc_en, sel_tap, en_out, listo, busy, overrun
  );

  modport slave (
    input  rx_done_tick, clr_ovr,
    output en_shift, acc_clr, acc_en, sel_tap, en_out, listo, busy, overrun
  );
endinterface

// File: rtl/filter_seq_ctrl.sv
// Control FSM for a tap-serial FIR: per sample, shift delay line, clear accumulator,
// run TAPS MAC cycles, then strobe the output register. Queues one extra sample.
module filter_seq_ctrl #(
  parameter int TAPS  = 5,
  parameter int IDX_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  filter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic             pend_reg, pend_next;
  logic             ovr_reg, ovr_next;
  logic             drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    drop       = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.rx_done_tick) state_next = SHIFT;
      end
      SHIFT: begin
        state_next = MAC;
        cnt_next   = '0;
      end
      MAC: begin
        if (cnt_reg == LAST_TAP) begin
          state_next = WRITE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WRITE: begin
        // A tick here starts the next pass directly unless one is already queued,
        // in which case the queued sample wins and this tick is lost.
        drop       = pend_reg & bus.rx_done_tick;
        state_next = (pend_reg | bus.rx_done_tick) ? SHIFT : IDLE;
        pend_next  = 1'b0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        pend_next  = 1'b0;
      end
    endcase

    if ((state_reg == SHIFT || state_reg == MAC) && bus.rx_done_tick) begin
      if (pend_reg) drop = 1'b1;
      else          pend_next = 1'b1;
    end

    if (drop)             ovr_next = 1'b1;
    else if (bus.clr_ovr) ovr_next = 1'b0;
    else                  ovr_next = ovr_reg;
  end

  always_comb begin
    bus.en_shift = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.acc_en   = 1'b0;
    bus.sel_tap  = '0;
    bus.en_out   = 1'b0;
    bus.listo    = 1'b0;
    bus.busy     = 1'b0;
    case (state_reg)
      SHIFT: begin
        bus.en_shift = 1'b1;
        bus.acc_clr  = 1'b1;
        bus.busy     = 1'b1;
      end
      MAC: begin
        bus.acc_en  = 1'b1;
        bus.sel_tap = cnt_reg;
        bus.busy    = 1'b1;
      end
      WRITE: begin
        bus.en_out = 1'b1;
        bus.listo  = 1'b1;
        bus.busy   = 1'b1;
      end
      default: ;
    endcase
    bus.overrun = ovr_reg;
  end

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Bench for filter_seq_ctrl: a pass-phase model checked every cycle (TAPS=5),
// plus literal expectations from logged outputs for both TAPS=5 and TAPS=1.
module tb_filter_seq_ctrl;
  localparam int TAPS = 5;

  typedef struct packed {
    logic       en_shift;
    logic       acc_clr;
    logic       acc_en;
    logic [2:0] sel;
    logic       en_out;
    logic       listo;
    logic       busy;
    logic       overrun;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  filter_seq_ctrl_if #(.IDX_W(3)) b5 ();
  filter_seq_ctrl_if #(.IDX_W(1)) b1 ();

  filter_seq_ctrl #(.TAPS(5), .IDX_W(3)) u5 (.clk(clk), .reset(reset), .bus(b5.slave));
  filter_seq_ctrl #(.TAPS(1), .IDX_W(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  int   cyc = 0;
  int   base = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   model_on = 1'b0;
  obs_t log5 [64];
  obs_t log1 [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc - base);
  endtask

  function automatic obs_t mk(bit es, bit ac, bit ae, int sel, bit eo, bit li, bit bs, bit ov);
    obs_t o;
    o.en_shift = es; o.acc_clr = ac; o.acc_en = ae; o.sel = 3'(sel);
    o.en_out = eo; o.listo = li; o.busy = bs; o.overrun = ov;
    return o;
  endfunction

  function automatic obs_t obs5();
    return mk(b5.en_shift, b5.acc_clr, b5.acc_en, int'(b5.sel_tap),
              b5.en_out, b5.listo, b5.busy, b5.overrun);
  endfunction

  function automatic obs_t obs1();
    return mk(b1.en_shift, b1.acc_clr, b1.acc_en, int'(b1.sel_tap),
              b1.en_out, b1.listo, b1.busy, b1.overrun);
  endfunction

  // Model: a pass is phase 0 (shift), 1..TAPS (MAC), TAPS+1 (write).
  bit m_active, m_pend, m_ovr, m_tk, m_drop;
  int m_ph;
  always @(posedge clk) begin
    m_tk = b5.rx_done_tick;
    m_drop = 1'b0;
    if (reset) begin
      m_active = 0; m_ph = 0; m_pend = 0; m_ovr = 0;
    end else begin
      if (!m_active) begin
        if (m_tk) begin m_active = 1; m_ph = 0; end
      end else if (m_ph == TAPS + 1) begin
        m_drop = m_pend && m_tk;
        if (m_pend || m_tk) m_ph = 0;
        else m_active = 0;
        m_pend = 0;
      end else begin
        if (m_tk) begin
          if (m_pend) m_drop = 1;
          else m_pend = 1;
        end
        m_ph++;
      end
      if (m_drop) m_ovr = 1;
      else if (b5.clr_ovr) m_ovr = 0;
    end
  end

  function automatic obs_t model_obs();
    bit ae;
    ae = m_active && m_ph >= 1 && m_ph <= TAPS;
    return mk(m_active && m_ph == 0, m_active && m_ph == 0, ae, ae ? m_ph - 1 : 0,
              m_active && m_ph == TAPS + 1, m_active && m_ph == TAPS + 1, m_active, m_ovr);
  endfunction

  always @(negedge clk) begin
    if (cyc - base >= 0 && cyc - base < 64) begin
      log5[cyc - base] = obs5();
      log1[cyc - base] = obs1();
    end
    if (model_on) check("model", int'(obs5()), int'(model_obs()));
  end

  task automatic goto(input int c);
    while (cyc < base + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    b5.rx_done_tick = 0; b5.clr_ovr = 0;
    b1.rx_done_tick = 0; b1.clr_ovr = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = cyc;
    for (int i = 0; i < 64; i++) begin
      log5[i] = '0;
      log1[i] = '0;
    end
  endtask

  task automatic tick5(input int c);
    goto(c);
    b5.rx_done_tick = 1'b1;
    goto(c + 1);
    b5.rx_done_tick = 1'b0;
  endtask

  function automatic int listo_count(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) n += int'(log5[i].listo);
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    int   busy_low, ovr_hi;

    // Single pass, plus TAPS=1 instance
    do_reset();
    model_on = 1'b1;
    goto(5);  b1.rx_done_tick = 1;
    goto(6);  b1.rx_done_tick = 0;
    tick5(10);
    goto(20);
    check("s1_reset_state", int'(log5[2]), 0);
    for (int c = 10; c <= 18; c++) begin
      if (c == 11) e = mk(1, 1, 0, 0, 0, 0, 1, 0);
      else if (c >= 12 && c <= 16) e = mk(0, 0, 1, c - 12, 0, 0, 1, 0);
      else if (c == 17) e = mk(0, 0, 0, 0, 1, 1, 1, 0);
      else e = '0;
      check($sformatf("s1_obs_c%0d", c), int'(log5[c]), int'(e));
    end
    check("t1_idle", int'(log1[5]), 0);
    check("t1_shift", int'(log1[6]), int'(mk(1, 1, 0, 0, 0, 0, 1, 0)));
    check("t1_mac", int'(log1[7]), int'(mk(0, 0, 1, 0, 0, 0, 1, 0)));
    check("t1_write", int'(log1[8]), int'(mk(0, 0, 0, 0, 1, 1, 1, 0)));
    check("t1_done", int'(log1[9]), 0);

    // Back-to-back at the sustainable rate
    do_reset();
    for (int k = 0; k < 4; k++) tick5(10 + 7 * k);
    goto(45);
    for (int k = 0; k < 4; k++) check($sformatf("s2_listo%0d", k), int'(log5[17 + 7 * k].listo), 1);
    for (int k = 0; k < 3; k++) check($sformatf("s2_reshift%0d", k), int'(log5[18 + 7 * k].en_shift), 1);
    busy_low = 0; ovr_hi = 0;
    for (int c = 11; c <= 38; c++) busy_low += int'(!log5[c].busy);
    for (int c = 0; c <= 44; c++) ovr_hi += int'(log5[c].overrun);
    check("s2_busy_gaps", busy_low, 0);
    check("s2_overrun", ovr_hi, 0);
    check("s2_listo_count", listo_count(0, 44), 4);
    check("s2_idle_after", int'(log5[39].busy), 0);

    // One queued sample
    do_reset();
    tick5(10);
    tick5(13);
    goto(30);
    check("s3_shift2", int'(log5[18].en_shift), 1);
    check("s3_listo2", int'(log5[24].listo), 1);
    check("s3_listo_count", listo_count(0, 29), 2);
    check("s3_idle", int'(log5[25].busy), 0);
    check("s3_overrun", int'(log5[26].overrun), 0);

    // Dropped sample, clear, then clear colliding with a new drop
    do_reset();
    tick5(10);
    tick5(13);
    tick5(14);
    goto(30); b5.clr_ovr = 1;
    goto(31); b5.clr_ovr = 0;
    tick5(40);
    tick5(43);
    goto(44); b5.rx_done_tick = 1; b5.clr_ovr = 1;
    goto(45); b5.rx_done_tick = 0; b5.clr_ovr = 0;
    goto(60);
    check("s4_ovr_before", int'(log5[14].overrun), 0);
    check("s4_ovr_set", int'(log5[15].overrun), 1);
    check("s4_ovr_sticky", int'(log5[30].overrun), 1);
    check("s4_ovr_clr", int'(log5[31].overrun), 0);
    check("s4_listo_count1", listo_count(0, 30), 2);
    check("s4_listo24", int'(log5[24].listo), 1);
    check("s4_ovr_pre2", int'(log5[44].overrun), 0);
    check("s4_set_wins", int'(log5[45].overrun), 1);
    check("s4_listo_count2", listo_count(31, 59), 2);

    // Reset mid-MAC abandons the pass
    do_reset();
    tick5(10);
    goto(14); reset = 1;
    goto(15); reset = 0;
    tick5(20);
    goto(35);
    check("s5_pre_reset_mac", int'(log5[14]), int'(mk(0, 0, 1, 2, 0, 0, 1, 0)));
    check("s5_post_reset", int'(log5[15]), 0);
    check("s5_no_listo", listo_count(0, 26), 0);
    check("s5_shift", int'(log5[21].en_shift), 1);
    check("s5_listo", int'(log5[27].listo), 1);
    check("s5_idle", int'(log5[28].busy), 0);

    model_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
